// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF (IEC 60958) transmitter.
package spdif_pkg;

    localparam int AUDIO_WIDTH      = 24;
    localparam int UI_PER_SUBFRAME  = 64;
    localparam int FRAMES_PER_BLOCK = 192;
    localparam int PREAMBLE_UIS     = 8;
    localparam int CAPTURE_UI       = 6;

    // Subframe bit positions; bit n occupies UIs 2n and 2n+1.
    localparam int BIT_POS_AUDIO = 4;
    localparam int BIT_POS_V     = 28;
    localparam int BIT_POS_U     = 29;
    localparam int BIT_POS_C     = 30;
    localparam int BIT_POS_P     = 31;

    // Preamble line patterns for a previous line level of 0, first UI in the MSB.
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    typedef enum logic [1:0] {
        PRE_SEL_B,
        PRE_SEL_M,
        PRE_SEL_W
    } pre_sel_t;

    function automatic logic [7:0] preamble_pattern(input pre_sel_t sel);
        case (sel)
            PRE_SEL_B: return PRE_B;
            PRE_SEL_M: return PRE_M;
            default:   return PRE_W;
        endcase
    endfunction

endpackage

// File: rtl/spdif_tx_if.sv
// Audio-source side of the S/PDIF transmitter: sample/status inputs,
// per-subframe requests, timing flags and the serial line.
interface spdif_tx_if;
    import spdif_pkg::*;

    logic [AUDIO_WIDTH-1:0] I_audio_d;
    logic                   I_validity_bit;
    logic                   I_user_bit;
    logic                   I_chan_status_bit;
    logic                   O_audio_d_req;
    logic                   O_validity_bit_req;
    logic                   O_user_bit_req;
    logic                   O_chan_status_bit_req;
    logic                   O_block_start_flag;
    logic                   O_sub_frame0_flag;
    logic                   O_sub_frame1_flag;
    logic                   O_Spdif_tx_data;

    // Audio source: supplies samples and status bits, consumes requests/flags.
    modport master (
        output I_audio_d, I_validity_bit, I_user_bit, I_chan_status_bit,
        input  O_audio_d_req, O_validity_bit_req, O_user_bit_req,
        input  O_chan_status_bit_req, O_block_start_flag,
        input  O_sub_frame0_flag, O_sub_frame1_flag, O_Spdif_tx_data
    );

    // Transmitter.
    modport slave (
        input  I_audio_d, I_validity_bit, I_user_bit, I_chan_status_bit,
        output O_audio_d_req, O_validity_bit_req, O_user_bit_req,
        output O_chan_status_bit_req, O_block_start_flag,
        output O_sub_frame0_flag, O_sub_frame1_flag, O_Spdif_tx_data
    );

endinterface

// File: rtl/spdif_bmc_enc.sv
// Biphase-mark / preamble encoder: next line level for one UI, given the
// level currently on the line.
module spdif_bmc_enc
    import spdif_pkg::*;
(
    input  logic     bit_val,
    input  logic [5:0] ui_phase,
    input  pre_sel_t pre_sel,
    input  logic     prev_level,
    output logic     line_level
);

    logic [8:0] pat_ext;
    logic [3:0] pos;

    // Preamble UIs replay the pattern as relative toggles (so a line at 1
    // yields the inverted pattern); data UIs apply biphase-mark coding.
    always_comb begin
        pat_ext = {1'b0, preamble_pattern(pre_sel)};
        pos     = 4'd7 - {1'b0, ui_phase[2:0]};
        if (ui_phase < 6'(PREAMBLE_UIS)) begin
            line_level = prev_level ^ pat_ext[pos] ^ pat_ext[pos + 4'd1];
        end else if (!ui_phase[0]) begin
            line_level = ~prev_level;
        end else begin
            line_level = prev_level ^ bit_val;
        end
    end

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF transmitter top: UI/subframe/frame counters, payload capture with
// even parity, registered flags/requests and the serial line.
module spdif_tx
    import spdif_pkg::*;
(
    input logic       I_clk,
    input logic       I_rst,
    spdif_tx_if.slave bus
);

    localparam logic [5:0] UI_LAST    = 6'(UI_PER_SUBFRAME - 1);
    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_BLOCK - 1);

    // Position of the UI that the next clock edge will put on the outputs.
    logic [5:0]  ui_cnt;
    logic        sub_idx;
    logic [7:0]  frame_cnt;

    logic [31:0] payload;
    logic        parity;
    logic        bit_val;
    pre_sel_t    pre_sel;
    logic        line_d;

    logic        req_q;
    logic        blk_q;
    logic        sf0_q;
    logic        sf1_q;
    logic        line_q;

    // Preamble choice: B opens a block, M other left subframes, W right ones.
    always_comb begin
        // NOTE: every path assigns pre_sel, so no latch is inferred.
        if (!sub_idx) begin
            pre_sel = (frame_cnt == 8'd0) ? PRE_SEL_B : PRE_SEL_M;
        end else begin
            pre_sel = PRE_SEL_W;
        end
    end

    assign parity  = ^{bus.I_audio_d, bus.I_validity_bit, bus.I_user_bit, bus.I_chan_status_bit};
    assign bit_val = payload[ui_cnt[5:1]];

    spdif_bmc_enc u_enc (
        .bit_val    (bit_val),
        .ui_phase   (ui_cnt),
        .pre_sel    (pre_sel),
        .prev_level (line_q),
        .line_level (line_d)
    );

    // UI, subframe and frame counters; all wraps resolve on the same edge.
    always_ff @(posedge I_clk) begin
        // NOTE: non-blocking assignments make every register see pre-edge values, independent of statement order.
        if (I_rst) begin
            ui_cnt    <= '0;
            sub_idx   <= 1'b0;
            frame_cnt <= '0;
        end else if (ui_cnt == UI_LAST) begin
            ui_cnt  <= '0;
            sub_idx <= ~sub_idx;
            if (sub_idx) begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? 8'd0 : frame_cnt + 8'd1;
            end
        end else begin
            ui_cnt <= ui_cnt + 6'd1;
        end
    end

    // Sample audio, V, U, C and the derived parity on the edge producing UI 6.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            payload <= '0;
        end else if (ui_cnt == 6'(CAPTURE_UI)) begin
            payload[BIT_POS_AUDIO-1:0]               <= '0;
            payload[BIT_POS_AUDIO +: AUDIO_WIDTH]    <= bus.I_audio_d;
            payload[BIT_POS_V]                       <= bus.I_validity_bit;
            payload[BIT_POS_U]                       <= bus.I_user_bit;
            payload[BIT_POS_C]                       <= bus.I_chan_status_bit;
            payload[BIT_POS_P]                       <= parity;
        end
    end

    // Registered outputs, all describing the same UI as the line level.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            req_q  <= 1'b0;
            blk_q  <= 1'b0;
            sf0_q  <= 1'b0;
            sf1_q  <= 1'b0;
            line_q <= 1'b0;
        end else begin
            req_q  <= (ui_cnt == 6'd0);
            blk_q  <= !sub_idx && (frame_cnt == 8'd0);
            sf0_q  <= !sub_idx;
            sf1_q  <= sub_idx;
            line_q <= line_d;
        end
    end

    assign bus.O_audio_d_req         = req_q;
    assign bus.O_validity_bit_req    = req_q;
    assign bus.O_user_bit_req        = req_q;
    assign bus.O_chan_status_bit_req = req_q;
    assign bus.O_block_start_flag    = blk_q;
    assign bus.O_sub_frame0_flag     = sf0_q;
    assign bus.O_sub_frame1_flag     = sf1_q;
    assign bus.O_Spdif_tx_data       = line_q;

endmodule

// File: tb/tb_spdif_tx.sv
// Testbench for spdif_tx: a driver answers each request with a directed
// vector and queues the expected subframe; a monitor decodes the serial line
// over 64 UIs and compares against the queue.
module tb_spdif_tx;

    localparam logic [7:0] EXP_B = 8'b11101000;
    localparam logic [7:0] EXP_M = 8'b11100010;
    localparam logic [7:0] EXP_W = 8'b11100100;

    typedef struct packed {
        logic [23:0] audio;
        logic        v;
        logic        u;
        logic        c;
        logic        p;   // hand-computed even parity over audio, V, U, C
    } vec_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [7:0]  pre;
        logic [27:0] payload;
        logic        sf1;
        logic        blk;
    } exp_t;

    vec_t vecs [6] = '{
        '{24'hA5A5A5, 1'b0, 1'b1, 1'b0, 1'b1},
        '{24'h000000, 1'b0, 1'b0, 1'b0, 1'b0},
        '{24'hFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1},
        '{24'h800001, 1'b1, 1'b0, 1'b0, 1'b1},
        '{24'h123456, 1'b0, 1'b0, 1'b1, 1'b0},
        '{24'h5A5A5A, 1'b1, 1'b0, 1'b1, 1'b0}
    };

    logic I_clk = 1'b0;
    logic I_rst = 1'b1;

    always #5 I_clk = ~I_clk;

    spdif_tx_if bus();

    spdif_tx dut (
        .I_clk (I_clk),
        .I_rst (I_rst),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    bit   mon_en = 1'b0;
    bit   abort  = 1'b0;
    int   sf_idx = 0;

    // Monitor state
    logic [63:0] lv, rq_any, f0v, f1v, fbv;
    logic [3:0]  rq0;
    int          ui = 0;
    bit          synced = 1'b0;
    logic        prev_lvl = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] all_outputs();
        return {bus.O_block_start_flag, bus.O_sub_frame0_flag, bus.O_sub_frame1_flag,
                bus.O_audio_d_req, bus.O_validity_bit_req, bus.O_user_bit_req,
                bus.O_chan_status_bit_req, bus.O_Spdif_tx_data};
    endfunction

    task automatic finish_subframe();
        exp_t        e;
        logic [7:0]  pre;
        logic [27:0] dec;
        bit          bp_ok;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: subframe seen, got no expectation, expected one queued");
            prev_lvl = lv[63];
            return;
        end
        e = sb_q.pop_front();
        for (int i = 0; i < 8; i++) pre[7-i] = lv[i];
        pre = pre ^ {8{prev_lvl}};
        check($sformatf("sf%0d preamble", e.idx), 64'(pre), 64'(e.pre));
        bp_ok = 1'b1;
        for (int n = 4; n < 32; n++) begin
            if (lv[2*n] == lv[2*n-1]) bp_ok = 1'b0;
            dec[n-4] = lv[2*n] ^ lv[2*n+1];
        end
        check($sformatf("sf%0d bit_start_toggle", e.idx), 64'(bp_ok), 64'd1);
        check($sformatf("sf%0d payload", e.idx), 64'(dec), 64'(e.payload));
        check($sformatf("sf%0d end_level", e.idx), 64'(lv[63]), 64'(prev_lvl));
        check($sformatf("sf%0d req_ui0", e.idx), 64'(rq0), 64'hF);
        check($sformatf("sf%0d req_only_ui0", e.idx), rq_any, 64'd1);
        check($sformatf("sf%0d sf0_flag", e.idx), f0v, {64{~e.sf1}});
        check($sformatf("sf%0d sf1_flag", e.idx), f1v, {64{e.sf1}});
        check($sformatf("sf%0d block_flag", e.idx), fbv, {64{e.blk}});
        prev_lvl = lv[63];
    endtask

    // Monitor: locks onto the first request, then collects 64 UIs per subframe.
    always @(negedge I_clk) begin
        if (!mon_en) begin
            synced   = 1'b0;
            prev_lvl = 1'b0;
            ui       = 0;
        end else begin
            if (!synced && bus.O_audio_d_req) begin
                synced = 1'b1;
                ui     = 0;
            end
            if (synced) begin
                lv[ui]     = bus.O_Spdif_tx_data;
                rq_any[ui] = bus.O_audio_d_req | bus.O_validity_bit_req |
                             bus.O_user_bit_req | bus.O_chan_status_bit_req;
                f0v[ui]    = bus.O_sub_frame0_flag;
                f1v[ui]    = bus.O_sub_frame1_flag;
                fbv[ui]    = bus.O_block_start_flag;
                if (ui == 0) begin
                    rq0 = {bus.O_audio_d_req, bus.O_validity_bit_req,
                           bus.O_user_bit_req, bus.O_chan_status_bit_req};
                end
                if (ui == 63) begin
                    finish_subframe();
                    ui = 0;
                end else begin
                    ui++;
                end
            end
        end
    end

    task automatic wait_req(output bit ok);
        int t = 0;
        @(negedge I_clk);
        while (bus.O_audio_d_req !== 1'b1 && t < 200) begin
            @(negedge I_clk);
            t++;
        end
        ok = (t < 200);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no request within 200 cycles, expected one every 64");
            abort = 1'b1;
        end
    endtask

    // Answer one request: drive the vector after req falls, push the
    // expectation, then scramble the inputs once UI 6 has been sampled.
    task automatic drive_one();
        bit   ok;
        vec_t v;
        exp_t e;
        wait_req(ok);
        if (!ok) return;
        v = vecs[sf_idx % 6];
        @(posedge I_clk);
        #1;
        bus.I_audio_d         = v.audio;
        bus.I_validity_bit    = v.v;
        bus.I_user_bit        = v.u;
        bus.I_chan_status_bit = v.c;
        e.idx     = 32'(sf_idx);
        e.blk     = (sf_idx % 384) == 0;
        e.sf1     = (sf_idx % 2) == 1;
        e.pre     = e.blk ? EXP_B : (e.sf1 ? EXP_W : EXP_M);
        e.payload = {v.p, v.c, v.u, v.v, v.audio};
        sb_q.push_back(e);
        repeat (6) @(posedge I_clk);
        #1;
        bus.I_audio_d         = ~v.audio;
        bus.I_validity_bit    = ~v.v;
        bus.I_user_bit        = ~v.u;
        bus.I_chan_status_bit = ~v.c;
        sf_idx++;
    endtask

    task automatic drive_n(input int n);
        for (int i = 0; i < n && !abort; i++) drive_one();
    endtask

    task automatic first_cycle_checks();
        @(negedge I_clk);
        check("first_ui_flags_reqs", 64'(all_outputs() >> 1), 64'b1101111);
        check("first_ui_level", 64'(bus.O_Spdif_tx_data), 64'd1);
        @(negedge I_clk);
        check("req_one_cycle", 64'(all_outputs() >> 1), 64'b1100000);
    endtask

    initial begin
        bit ok;
        bus.I_audio_d         = '0;
        bus.I_validity_bit    = 1'b0;
        bus.I_user_bit        = 1'b0;
        bus.I_chan_status_bit = 1'b0;

        repeat (5) @(posedge I_clk);
        @(negedge I_clk);
        check("reset_outputs", 64'(all_outputs()), 64'd0);

        I_rst  = 1'b0;
        mon_en = 1'b1;
        sf_idx = 0;
        fork
            first_cycle_checks();
            drive_n(394);
        join

        // Subframe 394 is frame 5, subframe 0 of the second block: reset at UI 30.
        if (!abort) begin
            wait_req(ok);
            if (ok) begin
                repeat (29) @(posedge I_clk);
                #1;
                I_rst  = 1'b1;
                mon_en = 1'b0;
                sb_q.delete();
                @(posedge I_clk);
                @(negedge I_clk);
                check("mid_reset_outputs", 64'(all_outputs()), 64'd0);
                repeat (2) @(posedge I_clk);
                @(negedge I_clk);
                I_rst  = 1'b0;
                mon_en = 1'b1;
                sf_idx = 0;
                fork
                    first_cycle_checks();
                    drive_n(3);
                join
                repeat (70) @(negedge I_clk);
                check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spdif_tx.md
Name: spdif_tx

Overview:
S/PDIF (IEC 60958) transmitter. It frames 24-bit audio samples plus validity, user and channel-status bits into 32-bit subframes. The subframes are grouped into 2-subframe frames and 192-frame blocks, then biphase-mark encoded onto one serial line. The block requests each input field per subframe and emits block and subframe timing flags for the upstream audio source. One I_clk cycle equals one half-bit (UI), so I_clk = 128 × Fs.

Parameters:
AUDIO_WIDTH, 24, audio sample width; fixed at 24, bits 4..27 of the subframe.
FRAMES_PER_BLOCK, 192, frames per channel-status block.

Ports:
I_clk  in  1  UI clock; all logic on the rising edge.
I_rst  in  1  synchronous reset, active-high.
I_audio_d  in  24  audio sample, LSB sent first.
I_validity_bit  in  1  V bit for the current subframe.
I_user_bit  in  1  U bit.
I_chan_status_bit  in  1  C bit.
O_audio_d_req  out  1  one-cycle request for the next sample.
O_validity_bit_req  out  1  one-cycle request for V.
O_user_bit_req  out  1  one-cycle request for U.
O_chan_status_bit_req  out  1  one-cycle request for C.
O_block_start_flag  out  1  high during the B subframe (frame 0, subframe 0).
O_sub_frame0_flag  out  1  high during subframe 0 (left).
O_sub_frame1_flag  out  1  high during subframe 1 (right).
O_Spdif_tx_data  out  1  biphase-mark serial output.

Behaviour:
- Reset (I_rst=1 at a clock edge) clears every output to 0, the UI counter (0..63), the subframe index, the frame counter (0..191) and the line-level register to 0. Reset mid-operation aborts the current subframe.
- Timing: the first clock edge with I_rst=0 outputs UI 0 of frame 0, subframe 0. After that the position advances one UI per clock:
  - UI wraps at 63, which toggles the subframe.
  - The subframe 1→0 transition increments the frame counter, which wraps 191→0.
- All outputs are registered and aligned, so flags and data describe the same UI.
- Flags:
  - O_sub_frame0_flag / O_sub_frame1_flag are high for all 64 UIs of their subframe and are mutually exclusive.
  - O_block_start_flag is high for the 64 UIs of subframe 0 of frame 0.
- Requests: all four *_req outputs pulse high for exactly the UI-0 cycle of every subframe. The source updates its inputs after the falling edge of req.
- Capture: I_audio_d, V, U and C are sampled at the edge that produces UI 6. Parity P = XOR of audio[23:0], V, U and C (even parity over bits 4..31).
- Subframe bits: 0–3 are the preamble, 4–27 are audio[0]..audio[23], then 28=V, 29=U, 30=C, 31=P. Bit n occupies UI 2n and 2n+1.
- Preamble (UI 0–7), driven from fixed patterns. Patterns are for a previous line level of 0; invert the whole pattern if the previous level (last UI of the prior subframe) is 1:
  - B = 11101000, for the first subframe of a block.
  - M = 11100010, for subframe 0 of all other frames.
  - W = 11100100, for subframe 1.
- Data bits (UI 8–63), biphase-mark coding:
  - The level toggles at the start of every bit (UI 2n).
  - The level toggles again at mid-bit (UI 2n+1) only if the bit is 1.
- Because even parity is used, every subframe ends at the same level it began with. After reset the first preamble uses the level-0 patterns.
- Simultaneous events: the UI-63→0 wrap, subframe toggle and frame increment all resolve in the same edge, with no dead cycles.
- Inputs that change outside the UI-6 edge have no effect.

Decomposition:
- Shared package spdif_pkg:
  - preamble constants PRE_B/PRE_M/PRE_W (8-bit);
  - UI_PER_SUBFRAME=64;
  - FRAMES_PER_BLOCK=192;
  - subframe bit-position constants (V=28, U=29, C=30, P=31).
- One natural sub-module, spdif_bmc_enc: it takes the bit value, the UI phase, the preamble select and the previous level, and produces the line level. The top level holds the counters, capture/shift register, parity and flags.

Test Plan:
- Reset held 5 cycles → all outputs 0. First cycle after release: O_sub_frame0_flag=1, O_block_start_flag=1, all four reqs=1 for exactly 1 cycle. First 8 output UIs = 11101000.
- Audio 24'hA5A5A5, V=0, U=1, C=0 → decoded bits 4..27 LSB-first = 0xA5A5A5, bit28=0, bit29=1, bit30=0, P=1. Line level at UI 63 equals the level before UI 0.
- Audio 24'h000000, V=U=C=0 → P=0. Data UIs show a toggle only at even UIs, i.e. a 1,1,0,0 cadence.
- Count 64 cycles → subframe 1 begins with the W pattern (11100100 or its inverse). Cycle 128 → M pattern. O_block_start_flag low for frames 1..191.
- After 192×128=24576 cycles → B preamble and O_block_start_flag reappear. Reqs pulse every 64 cycles, never adjacent.
- Assert I_rst at UI 30 of frame 5 → outputs 0 next cycle. On release → frame 0, B preamble with level-0 pattern.
